// File: rtl/div_engine_pkg.sv
// Shared types and constants for the div_engine restoring divider.
// Falls back to a 32-bit DATALENGTH when the CPU-wide define is absent.
`ifndef DATALENGTH
`define DATALENGTH 32
`endif

package div_engine_pkg;

  localparam int DATA_WIDTH = `DATALENGTH;
  localparam int DIV_ITER   = 32;
  localparam int CNT_WIDTH  = 5;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } divState_e;

endpackage

// File: rtl/div_engine_step.sv
// One combinational restoring-division step on the packed {rem, quot} pair.
module div_engine_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] remQuotIn,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] remQuotOut
);

  logic [WIDTH:0]   remShift;
  logic [WIDTH-1:0] trial;
  logic             fits;

  // The shifted remainder may carry one bit past WIDTH, so compare on WIDTH+1 bits.
  assign remShift = remQuotIn[2*WIDTH-1:WIDTH-1];
  assign fits     = (remShift >= {1'b0, divisor});
  // When fits is set the difference is below the divisor, so WIDTH bits hold it exactly.
  assign trial    = remShift[WIDTH-1:0] - divisor;

  assign remQuotOut = {fits ? trial : remShift[WIDTH-1:0], remQuotIn[WIDTH-2:0], fits};

endmodule

// File: rtl/div_engine.sv
// Multi-cycle MIPS DIV/DIVU engine producing the HI (remainder) / LO (quotient) pair.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and completes at T+1.
module div_engine
  import div_engine_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             div_busy,
  output logic             is_div,
  output logic [WIDTH-1:0] div_high,
  output logic [WIDTH-1:0] div_low
);

  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DIV_ITER - 1);

  function automatic logic [WIDTH-1:0] condNeg(input logic [WIDTH-1:0] value, input logic neg);
    return neg ? -value : value;
  endfunction

  divState_e              state;
  logic [2*WIDTH-1:0]     remQuot;
  logic [2*WIDTH-1:0]     stepOut;
  logic [WIDTH-1:0]       divisorReg;
  logic [CNT_WIDTH-1:0]   iterCnt;
  logic                   quotNeg;
  logic                   remNeg;

  logic                   signA;
  logic                   signB;
  logic [WIDTH-1:0]       magA;
  logic [WIDTH-1:0]       magB;

  assign signA = div_signed & src_a[WIDTH-1];
  assign signB = div_signed & src_b[WIDTH-1];
  assign magA  = condNeg(src_a, signA);
  assign magB  = condNeg(src_b, signB);

  // Combinational so the issuing instruction stalls in its own cycle.
  assign div_busy = (state == DIV_CALC) | (div_start & ~flush & (state != DIV_CALC));

  div_engine_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .remQuotIn (remQuot),
    .divisor   (divisorReg),
    .remQuotOut(stepOut)
  );

  // NOTE: every register here is state, so all updates are non-blocking (<=).
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DIV_IDLE;
      is_div     <= 1'b0;
      div_high   <= '0;
      div_low    <= '0;
      remQuot    <= '0;
      divisorReg <= '0;
      iterCnt    <= '0;
      quotNeg    <= 1'b0;
      remNeg     <= 1'b0;
    end else begin
      is_div <= 1'b0;
      if (flush) begin
        state <= DIV_IDLE;
      end else begin
        case (state)
          DIV_CALC: begin
            remQuot <= stepOut;
            iterCnt <= iterCnt + 1'b1;
            if (iterCnt == LAST_ITER) begin
              state    <= DIV_DONE;
              is_div   <= 1'b1;
              div_low  <= condNeg(stepOut[WIDTH-1:0], quotNeg);
              div_high <= condNeg(stepOut[2*WIDTH-1:WIDTH], remNeg);
            end
          end
          default: begin
            if (div_start) begin
              quotNeg    <= signA ^ signB;
              remNeg     <= signA;
              divisorReg <= magB;
              remQuot    <= {{WIDTH{1'b0}}, magA};
              iterCnt    <= '0;
`ifdef DIV_ZERO_FAST_EN
              if (magB == '0) begin
                state    <= DIV_DONE;
                is_div   <= 1'b1;
                div_low  <= condNeg({WIDTH{1'b1}}, signA ^ signB);
                div_high <= condNeg(magA, signA);
              end else begin
                state <= DIV_CALC;
              end
`else
              state <= DIV_CALC;
`endif
            end else begin
              state <= DIV_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_div_engine.sv
// Directed self-checking bench for div_engine: latency, signs, overflow, divide-by-zero, flush, reset.
module tb_div_engine;
  import div_engine_pkg::*;

  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         div_start;
  logic         div_signed;
  logic         flush;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         div_busy;
  logic         is_div;
  logic [W-1:0] div_high;
  logic [W-1:0] div_low;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  div_engine #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .div_start (div_start),
    .div_signed(div_signed),
    .flush     (flush),
    .src_a     (src_a),
    .src_b     (src_b),
    .div_busy  (div_busy),
    .is_div    (is_div),
    .div_high  (div_high),
    .div_low   (div_low)
  );

  task automatic check(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Issues one division and returns at the negedge of the is_div cycle.
  task automatic runDiv(input string tag, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] expLow, input logic [W-1:0] expHigh, input int expLat,
                        input bit noWait);
    int lat = 0;
    if (!noWait) @(negedge clk);
    div_start  = 1'b1;
    div_signed = sgn;
    src_a      = a;
    src_b      = b;
    #1 check({tag, "_busy_T"}, W'(div_busy), 1);
    @(negedge clk);
    div_start = 1'b0;
    src_a     = $urandom;
    src_b     = $urandom;
    for (int n = 1; n <= 40; n++) begin
      if (n == expLat - 1) check({tag, "_busy_last"}, W'(div_busy), 1);
      if (is_div) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, W'(lat), W'(expLat));
    check({tag, "_busy_done"}, W'(div_busy), 0);
    check({tag, "_low"}, div_low, expLow);
    check({tag, "_high"}, div_high, expHigh);
  endtask

  initial begin
    int seen;
    rst        = 1'b1;
    div_start  = 1'b0;
    div_signed = 1'b0;
    flush      = 1'b0;
    src_a      = '0;
    src_b      = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_busy", W'(div_busy), 0);
    check("reset_is_div", W'(is_div), 0);
    check("reset_high", div_high, 0);
    check("reset_low", div_low, 0);

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0);
    @(negedge clk);
    check("strobe_one_cycle", W'(is_div), 0);
    check("hold_low", div_low, 32'd14);
    check("hold_high", div_high, 32'd2);

    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 1'b0);
    runDiv("divu_big_2", 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 33, 1'b0);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33, 1'b0);
    runDiv("divu_3_10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, 33, 1'b0);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, ZERO_LAT, 1'b0);
    runDiv("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'd1, 32'hFFFF_FFFB, ZERO_LAT, 1'b0);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33, 1'b0);
    // Issued in the DONE cycle of the overflow case.
    runDiv("b2b_divu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 33, 1'b1);

    // Flush at T+10, restart at T+12.
    seen = 0;
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = 1'b0;
    src_a      = 32'd77;
    src_b      = 32'd5;
    @(negedge clk);
    div_start = 1'b0;
    for (int n = 1; n < 10; n++) begin
      seen += int'(is_div);
      @(negedge clk);
    end
    flush = 1'b1;
    #1 check("flush_busy_T10", W'(div_busy), 1);
    @(negedge clk);
    flush = 1'b0;
    seen += int'(is_div);
    check("flush_idle_busy", W'(div_busy), 0);
    check("flush_no_is_div", W'(seen), 0);
    check("flush_low_kept", div_low, 32'd1);
    check("flush_high_kept", div_high, 32'd0);
    runDiv("after_flush", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 33, 1'b0);

    // Synchronous reset at T+20.
    @(negedge clk);
    div_start  = 1'b1;
    div_signed = 1'b1;
    src_a      = 32'hFFFF_FF00;
    src_b      = 32'd3;
    @(negedge clk);
    div_start = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_state", W'(dut.state), W'(DIV_IDLE));
    check("rst_busy", W'(div_busy), 0);
    check("rst_is_div", W'(is_div), 0);
    check("rst_low", div_low, 0);
    check("rst_high", div_high, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen += int'(is_div);
    end
    check("rst_no_late_is_div", W'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
